// File: rtl/epw22_stack_alu.sv
// Tagged stack-machine ALU: request captured at edge N, executed and answered at edge N+1.
// Optional EPW22_SATURATE_EN: ADD/MUL clamp to all-ones, SUB clamps to zero instead of wrapping.
module epw22_stack_alu #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] data,
  input  logic [TAG_W-1:0]  tag,
  output logic              ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  rtag,
  output logic              error
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_PUSH = 4'd1,  OP_POP  = 4'd2,  OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,  OP_MUL  = 4'd5,  OP_AND  = 4'd6,  OP_OR   = 4'd7,
    OP_XOR  = 4'd8,  OP_NOT  = 4'd9,  OP_DUP  = 4'd10, OP_SWAP = 4'd11,
    OP_CLR  = 4'd12, OP_PEEK = 4'd13
  } op_e;

  logic              req_vld_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] stk_q [DEPTH];
  logic [DATA_W-1:0] stk_d [DEPTH];
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic              ready_q;
  logic [DATA_W-1:0] result_q, res_d;
  logic [TAG_W-1:0]  rtag_q;
  logic              error_q, err_d;

  logic [PTR_W-1:0]    top_idx, nxt_idx, push_idx;
  logic [DATA_W-1:0]   a, b, alu_r;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic                full, empty, lt2;

  assign top_idx  = PTR_W'(depth_q - CNT_W'(1));
  assign nxt_idx  = top_idx - PTR_W'(1);
  assign push_idx = depth_q[PTR_W-1:0];
  assign a        = stk_q[top_idx];
  assign b        = stk_q[nxt_idx];
  assign full     = (depth_q == CNT_W'(DEPTH));
  assign empty    = (depth_q == '0);
  assign lt2      = (depth_q < CNT_W'(2));
  assign sum      = {1'b0, b} + {1'b0, a};
  assign prod     = {{DATA_W{1'b0}}, b} * {{DATA_W{1'b0}}, a};

  always_comb begin
    alu_r = '0;
    case (op_q)
`ifdef EPW22_SATURATE_EN
      OP_ADD: alu_r = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
      OP_SUB: alu_r = (b < a) ? '0 : b - a;
      OP_MUL: alu_r = (|prod[2*DATA_W-1:DATA_W]) ? '1 : prod[DATA_W-1:0];
`else
      OP_ADD: alu_r = sum[DATA_W-1:0];
      OP_SUB: alu_r = b - a;
      OP_MUL: alu_r = prod[DATA_W-1:0];
`endif
      OP_AND: alu_r = b & a;
      OP_OR:  alu_r = b | a;
      OP_XOR: alu_r = b ^ a;
      default: alu_r = '0;
    endcase
  end

  // Rejected requests never touch stk_d/depth_d, so the stack is left intact on error.
  always_comb begin
    stk_d   = stk_q;
    depth_d = depth_q;
    res_d   = '0;
    err_d   = 1'b0;
    if (req_vld_q) begin
      case (op_q)
        OP_NOP: res_d = '0;
        OP_PUSH: begin
          if (full) err_d = 1'b1;
          else begin
            stk_d[push_idx] = data_q;
            depth_d         = depth_q + CNT_W'(1);
            res_d           = data_q;
          end
        end
        OP_POP: begin
          if (empty) err_d = 1'b1;
          else begin
            depth_d = depth_q - CNT_W'(1);
            res_d   = a;
          end
        end
        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
          if (lt2) err_d = 1'b1;
          else begin
            stk_d[nxt_idx] = alu_r;
            depth_d        = depth_q - CNT_W'(1);
            res_d          = alu_r;
          end
        end
        OP_NOT: begin
          if (empty) err_d = 1'b1;
          else begin
            stk_d[top_idx] = ~a;
            res_d          = ~a;
          end
        end
        OP_DUP: begin
          if (empty || full) err_d = 1'b1;
          else begin
            stk_d[push_idx] = a;
            depth_d         = depth_q + CNT_W'(1);
            res_d           = a;
          end
        end
        OP_SWAP: begin
          if (lt2) err_d = 1'b1;
          else begin
            stk_d[top_idx] = b;
            stk_d[nxt_idx] = a;
            res_d          = b;
          end
        end
        OP_CLR: depth_d = '0;
        OP_PEEK: begin
          if (empty) err_d = 1'b1;
          else res_d = a;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_vld_q <= 1'b0;
      op_q      <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      stk_q     <= '{default: '0};
      depth_q   <= '0;
      ready_q   <= 1'b0;
      result_q  <= '0;
      rtag_q    <= '0;
      error_q   <= 1'b0;
    end else begin
      req_vld_q <= valid;
      if (valid) begin
        op_q   <= op;
        data_q <= data;
        tag_q  <= tag;
      end
      stk_q   <= stk_d;
      depth_q <= depth_d;
      ready_q <= req_vld_q;
      if (req_vld_q) begin
        result_q <= res_d;
        rtag_q   <= tag_q;
        error_q  <= err_d;
      end
    end
  end

  assign ready  = ready_q;
  assign result = result_q;
  assign rtag   = rtag_q;
  assign error  = error_q;
endmodule

// File: tb/tb_epw22_stack_alu.sv
// Directed bench for epw22_stack_alu; a response for a request driven at negedge k is sampled at negedge k+2.
module tb_epw22_stack_alu;
`ifdef EPW22_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [3:0]  op;
  logic [15:0] data;
  logic [3:0]  tag;
  logic        ready;
  logic [15:0] result;
  logic [3:0]  rtag;
  logic        error;

  int checks = 0;
  int errors = 0;

  epw22_stack_alu dut (
    .clk(clk), .reset(reset), .valid(valid), .op(op), .data(data), .tag(tag),
    .ready(ready), .result(result), .rtag(rtag), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [15:0] d, input logic [3:0] t);
    valid = 1'b1; op = o; data = d; tag = t;
  endtask

  task automatic resp(input string nm, input logic [15:0] er, input logic [3:0] et, input logic ee);
    chk({nm, ".ready"}, ready, 1);
    chk({nm, ".result"}, result, er);
    chk({nm, ".rtag"}, rtag, et);
    chk({nm, ".error"}, error, ee);
  endtask

  task automatic xact(input string nm, input logic [3:0] o, input logic [15:0] d,
                      input logic [3:0] t, input logic [15:0] er, input logic ee);
    @(negedge clk); drive(o, d, t);
    @(negedge clk); valid = 1'b0;
    @(negedge clk); resp(nm, er, t, ee);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; op = '0; data = '0; tag = '0;
    repeat (3) @(negedge clk);
    chk("rst.ready", ready, 0);
    chk("rst.result", result, 0);
    chk("rst.rtag", rtag, 0);
    chk("rst.error", error, 0);
    reset = 1'b0;

    // back-to-back PUSH 5, PUSH 3, ADD
    @(negedge clk); drive(4'd1, 16'd5, 4'd1);
    @(negedge clk); drive(4'd1, 16'd3, 4'd2);
    @(negedge clk); drive(4'd3, 16'd0, 4'd3); resp("b2b1", 16'd5, 4'd1, 1'b0);
    @(negedge clk); valid = 1'b0;             resp("b2b2", 16'd3, 4'd2, 1'b0);
    @(negedge clk);                           resp("b2b3", 16'd8, 4'd3, 1'b0);
    @(negedge clk);
    chk("hold.ready", ready, 0);
    chk("hold.result", result, 16'd8);
    chk("hold.rtag", rtag, 4'd3);

    xact("clr0", 4'd12, 16'd0, 4'd0, 16'd0, 1'b0);
    xact("pop_empty", 4'd2, 16'd0, 4'd7, 16'd0, 1'b1);
    xact("peek_empty", 4'd13, 16'd0, 4'd8, 16'd0, 1'b1);

    for (int i = 0; i < 8; i++) xact("fill", 4'd1, 16'd9, 4'(i), 16'd9, 1'b0);
    xact("push_full", 4'd1, 16'd9, 4'd9, 16'd0, 1'b1);
    xact("pop_full", 4'd2, 16'd0, 4'd10, 16'd9, 1'b0);
    xact("refill", 4'd1, 16'd9, 4'd11, 16'd9, 1'b0);
    xact("push_full2", 4'd1, 16'd9, 4'd12, 16'd0, 1'b1);
    xact("clr1", 4'd12, 16'd0, 4'd13, 16'd0, 1'b0);

    xact("pushFFFF", 4'd1, 16'hFFFF, 4'd1, 16'hFFFF, 1'b0);
    xact("push2", 4'd1, 16'd2, 4'd2, 16'd2, 1'b0);
    xact("add_ovf", 4'd3, 16'd0, 4'd3, SAT ? 16'hFFFF : 16'h0001, 1'b0);
    xact("clr2", 4'd12, 16'd0, 4'd4, 16'd0, 1'b0);

    xact("pushF0", 4'd1, 16'h00F0, 4'd1, 16'h00F0, 1'b0);
    xact("dup", 4'd10, 16'd0, 4'd2, 16'h00F0, 1'b0);
    xact("xor", 4'd8, 16'd0, 4'd3, 16'h0000, 1'b0);
    xact("op14", 4'd14, 16'd0, 4'd5, 16'd0, 1'b1);
    xact("op15", 4'd15, 16'd0, 4'd6, 16'd0, 1'b1);
    xact("clr3", 4'd12, 16'd0, 4'd7, 16'd0, 1'b0);
    xact("pop_after_clr", 4'd2, 16'd0, 4'd8, 16'd0, 1'b1);

    xact("push3", 4'd1, 16'd3, 4'd1, 16'd3, 1'b0);
    xact("push5", 4'd1, 16'd5, 4'd2, 16'd5, 1'b0);
    xact("sub_unf", 4'd4, 16'd0, 4'd3, SAT ? 16'h0000 : 16'hFFFE, 1'b0);
    xact("push4", 4'd1, 16'd4, 4'd4, 16'd4, 1'b0);
    xact("swap", 4'd11, 16'd0, 4'd5, SAT ? 16'h0000 : 16'hFFFE, 1'b0);
    xact("mul", 4'd5, 16'd0, 4'd6, SAT ? 16'h0000 : 16'hFFF8, 1'b0);
    xact("not", 4'd9, 16'd0, 4'd7, SAT ? 16'hFFFF : 16'h0007, 1'b0);
    xact("pushC", 4'd1, 16'h000C, 4'd8, 16'h000C, 1'b0);
    xact("or", 4'd7, 16'd0, 4'd9, SAT ? 16'hFFFF : 16'h000F, 1'b0);
    xact("push6", 4'd1, 16'd6, 4'd10, 16'd6, 1'b0);
    xact("and", 4'd6, 16'd0, 4'd11, 16'd6, 1'b0);
    xact("peek", 4'd13, 16'd0, 4'd12, 16'd6, 1'b0);
    xact("nop", 4'd0, 16'd0, 4'd13, 16'd0, 1'b0);
    xact("add_shallow", 4'd3, 16'd0, 4'd14, 16'd0, 1'b1);
    xact("swap_shallow", 4'd11, 16'd0, 4'd15, 16'd0, 1'b1);
    xact("dup6", 4'd10, 16'd0, 4'd1, 16'd6, 1'b0);
    xact("add12", 4'd3, 16'd0, 4'd2, 16'd12, 1'b0);

    // reset asserted while back-to-back pushes are in flight
    @(negedge clk); drive(4'd1, 16'h0011, 4'd3);
    @(negedge clk); drive(4'd1, 16'h0022, 4'd4);
    @(negedge clk); drive(4'd1, 16'h0033, 4'd5);
    chk("pre_rst.ready", ready, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst.ready", ready, 0);
    chk("mid_rst.result", result, 0);
    chk("mid_rst.rtag", rtag, 0);
    chk("mid_rst.error", error, 0);
    @(negedge clk); valid = 1'b0; reset = 1'b0;
    @(negedge clk); chk("post_rst1.ready", ready, 0);
    @(negedge clk); chk("post_rst2.ready", ready, 0);
    xact("pop_post_rst", 4'd2, 16'd0, 4'd6, 16'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
